// File: rtl/iob_cmd_master_if.sv
// Bundles the command, response and IOb master signals of iob_cmd_master.
// Signal suffixes describe direction as seen from the master (the DUT side).
interface iob_cmd_master_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_mode_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [5:0]        cmd_width_i;
  logic [31:0]       cmd_wdata_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;

  logic              iob_valid_o;
  logic [ADDR_W-1:0] iob_addr_o;
  logic [31:0]       iob_wdata_o;
  logic [3:0]        iob_wstrb_o;
  logic              iob_ready_i;
  logic              iob_rvalid_i;
  logic [31:0]       iob_rdata_i;

  modport master (
    input  cmd_valid_i, cmd_mode_i, cmd_addr_i, cmd_width_i, cmd_wdata_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  rsp_ready_i,
    output iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    input  iob_ready_i, iob_rvalid_i, iob_rdata_i
  );

  modport slave (
    output cmd_valid_i, cmd_mode_i, cmd_addr_i, cmd_width_i, cmd_wdata_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output rsp_ready_i,
    input  iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    output iob_ready_i, iob_rvalid_i, iob_rdata_i
  );
endinterface

// File: rtl/iob_cmd_master.sv
// Turns single byte-addressed commands of 1..32 bits into one IOb native
// access, with lane alignment, read extraction, timeout and error response.
//
// state | meaning
// IDLE  | ready for a command (cmd_ready_o=1)
// REQ   | IOb request driven, waiting for iob_ready_i
// RDATA | read accepted, waiting for iob_rvalid_i
// RSP   | response held until rsp_ready_i
module iob_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  iob_cmd_master_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2,
    RSP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:2] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [5:0]        width_q, width_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]  cmd_off;
  logic [3:0]  cmd_nbytes;
  logic        cmd_illegal;
  logic [3:0]  cmd_wstrb;
  logic [31:0] cmd_wdata_sh;
  logic [31:0] rd_shifted;
  logic [31:0] rd_mask;
  logic        timeout_hit;

  always_comb begin
    cmd_off      = bus.cmd_addr_i[1:0];
    cmd_nbytes   = 4'((7'(bus.cmd_width_i) + 7'd7) >> 3);
    cmd_illegal  = (bus.cmd_width_i == 6'd0) || (bus.cmd_width_i > 6'd32) ||
                   ((4'(cmd_off) + cmd_nbytes) > 4'd4);
    // only meaningful for legal commands, where the strobe fits in 4 lanes
    cmd_wstrb    = 4'(((5'd1 << cmd_nbytes) - 5'd1) << cmd_off);
    cmd_wdata_sh = bus.cmd_wdata_i << {cmd_off, 3'b000};
  end

  always_comb begin
    rd_shifted  = bus.iob_rdata_i >> {off_q, 3'b000};
    rd_mask     = (width_q >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << width_q) - 32'd1);
    timeout_hit = TO_EN && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      off_q   <= '0;
      width_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      width_q <= width_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    off_d   = off_q;
    width_d = width_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (cke_i) begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            write_d = bus.cmd_mode_i;
            addr_d  = bus.cmd_addr_i[ADDR_W-1:2];
            off_d   = cmd_off;
            width_d = bus.cmd_width_i;
            rdata_d = '0;
            cnt_d   = '0;
            if (cmd_illegal) begin
              err_d   = 1'b1;
              wdata_d = '0;
              wstrb_d = '0;
              state_d = RSP;
            end else begin
              err_d   = 1'b0;
              wdata_d = bus.cmd_mode_i ? cmd_wdata_sh : 32'd0;
              wstrb_d = bus.cmd_mode_i ? cmd_wstrb : 4'd0;
              state_d = REQ;
            end
          end
        end

        REQ: begin
          cnt_d = cnt_q + CNT_W'(1);
          // the awaited event takes priority over a coincident timeout
          if (bus.iob_ready_i) begin
            cnt_d   = '0;
            state_d = write_q ? RSP : RDATA;
          end else if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = RSP;
          end
        end

        RDATA: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.iob_rvalid_i) begin
            rdata_d = rd_shifted & rd_mask;
            state_d = RSP;
          end else if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = RSP;
          end
        end

        RSP: begin
          if (bus.rsp_ready_i) state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = (state_q == IDLE);
  assign bus.iob_valid_o = (state_q == REQ);
  assign bus.iob_addr_o  = {addr_q, 2'b00};
  assign bus.iob_wdata_o = wdata_q;
  assign bus.iob_wstrb_o = (state_q == REQ) ? wstrb_q : 4'd0;
  assign bus.rsp_valid_o = (state_q == RSP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

endmodule
